// File: rtl/riscv_if.sv
// Instruction fetch stage: issues word reads to instruction memory and hands
// {instruction, pc, valid} to decode, honouring stall and execute redirects.
module riscv_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        rst,
  input  logic        clk,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid,
  output logic        exception
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] HOLD = 3'd2;
  localparam logic [2:0] DROP = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    exc_d      = exc_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect && (state_q != HALT)) begin
      // Redirect always flushes the presented instruction, even on a would-be transfer edge.
      valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = HALT;
        req_d   = 1'b0;
        exc_d   = 1'b1;
      end else begin
        fetch_pc_d = redirect_pc;
        if (((state_q == WAIT) || (state_q == DROP)) && !imem_ack) begin
          // Request still in flight: keep req/addr stable and discard its data later.
          state_d = DROP;
        end else begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
        WAIT: begin
          if (imem_ack) begin
            state_d    = HOLD;
            instr_d    = imem_rdata;
            pc_d       = addr_q;
            valid_d    = 1'b1;
            fetch_pc_d = addr_q + 32'd4;
            req_d      = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_d = WAIT;
            valid_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        HALT: begin
          req_d   = 1'b0;
          valid_d = 1'b0;
          exc_d   = 1'b1;
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= NOP;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      exc_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      exc_q      <= exc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign valid       = valid_q;
  assign exception   = exc_q;
  assign instruction = valid_q ? instr_q : NOP;

endmodule

// File: tb/tb_riscv_if.sv
// Directed bench for riscv_if with a small instruction memory model whose ack latency is adjustable.
module tb_riscv_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;
  logic        exception;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mem_delay = 0;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  riscv_if dut (
    .rst(rst), .clk(clk),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .pc(pc), .valid(valid), .exception(exception)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h02A0_0293;
      32'h0000_0004: mem_word = 32'h0090_0313;
      32'h0000_0008: mem_word = 32'h1111_1111;
      32'h0000_0100: mem_word = 32'h0050_0513;
      32'hFFFF_FFFC: mem_word = 32'h0000_006F;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign imem_ack   = (imem_req && (wait_cnt >= mem_delay)) || force_ack;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, NOP_W);
    chk("rst_pc", pc, 32'h0);
    chk("rst_exc", {31'b0, exception}, 32'd0);

    // 1: first fetch at RESET_PC with zero-wait memory
    rst = 1'b0;
    tick();
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid_lo", {31'b0, valid}, 32'd0);
    tick();
    chk("t1_valid", {31'b0, valid}, 32'd1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_instr", instruction, 32'h02A0_0293);
    chk("t1_req_off", {31'b0, imem_req}, 32'd0);

    // 2: stall holds the presented instruction
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", {31'b0, valid}, 32'd1);
      chk("t2_hold_instr", instruction, 32'h02A0_0293);
      chk("t2_hold_pc", pc, 32'h0);
      chk("t2_hold_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("t2_req", {31'b0, imem_req}, 32'd1);
    chk("t2_addr", imem_addr, 32'h4);
    chk("t2_valid_lo", {31'b0, valid}, 32'd0);
    chk("t2_nop", instruction, NOP_W);
    tick();
    chk("t2_valid", {31'b0, valid}, 32'd1);
    chk("t2_pc", pc, 32'h4);
    chk("t2_instr", instruction, 32'h0090_0313);

    // 3: redirect during a slow fetch discards the stale word
    mem_delay = 3;
    tick();
    chk("t3_addr8", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("t3_drop_req", {31'b0, imem_req}, 32'd1);
    chk("t3_drop_addr", imem_addr, 32'h8);
    n = 0;
    while (imem_addr == 32'h8 && n < 12) begin
      chk("t3_drop_valid", {31'b0, valid}, 32'd0);
      tick();
      n++;
    end
    chk("t3_drop_done", {31'b0, n < 12}, 32'd1);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_new_req", {31'b0, imem_req}, 32'd1);
    n = 0;
    while (!valid && n < 12) begin
      tick();
      n++;
    end
    chk("t3_valid_seen", {31'b0, valid}, 32'd1);
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", instruction, 32'h0050_0513);
    mem_delay = 0;

    // 5: wrap of fetch_pc past the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("t5_flush", {31'b0, valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_valid", {31'b0, valid}, 32'd1);
    chk("t5_pc", pc, 32'hFFFF_FFFC);
    chk("t5_instr", instruction, 32'h0000_006F);
    tick();
    chk("t5_wrap_addr", imem_addr, 32'h0);
    chk("t5_wrap_req", {31'b0, imem_req}, 32'd1);

    // 4: misaligned redirect halts until reset
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    chk("t4_exc", {31'b0, exception}, 32'd1);
    chk("t4_valid", {31'b0, valid}, 32'd0);
    chk("t4_req", {31'b0, imem_req}, 32'd0);
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_halt_exc", {31'b0, exception}, 32'd1);
      chk("t4_halt_req", {31'b0, imem_req}, 32'd0);
      chk("t4_halt_valid", {31'b0, valid}, 32'd0);
    end
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_exc", {31'b0, exception}, 32'd0);
    chk("t4_rst_addr", imem_addr, 32'h0);
    mem_delay = 2;
    tick();
    rst = 1'b0;
    tick();
    chk("t4_restart_req", {31'b0, imem_req}, 32'd1);
    chk("t4_restart_addr", imem_addr, 32'h0);

    // 6: async reset in the middle of WAIT, late ack ignored
    tick();
    chk("t6_wait_req", {31'b0, imem_req}, 32'd1);
    chk("t6_wait_valid", {31'b0, valid}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'b0, imem_req}, 32'd0);
    chk("t6_rst_valid", {31'b0, valid}, 32'd0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_instr", instruction, NOP_W);
    force_ack = 1'b1;
    tick();
    chk("t6_late_ack_rst", {31'b0, valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_late_ack_idle", {31'b0, valid}, 32'd0);
    chk("t6_req", {31'b0, imem_req}, 32'd1);
    chk("t6_addr", imem_addr, 32'h0);
    force_ack = 1'b0;
    mem_delay = 0;
    tick();
    chk("t6_valid", {31'b0, valid}, 32'd1);
    chk("t6_pc", pc, 32'h0);
    chk("t6_instr", instruction, 32'h02A0_0293);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
